hpdmc_rdcapture: RTL and testbench

Parametrised read-data capture stage for the DDR datapath. Takes the per-edge samples produced by the input DDR registers (rising/falling, already in the system clock domain) and uses a programmable read latency to open a capture window of BURST beats after each read command. Packs each beat into a 2*DW word and buffers it in a small FIFO with a valid/ready interface toward the bus side. Sits between the I/O register bank and the controller's read-data return path; the burst alignment and backpressure are new functions.

---
 rtl/hpdmc_rdcapture.sv | 163 ++++++++++++++++
 tb/tb_hpdmc_rdcapture.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdmc_rdcapture.sv
// Purpose: turns DDR edge samples into {fall,rise} words, one burst of BURST beats per read, after a per-read latency.
// Latency: window opens cfg_lat cycles after read_start; each beat shows on out_valid one cycle after its capture.
// Backpressure: out_valid/out_ready FIFO; a beat arriving while the FIFO is full (and not popped) is dropped and flagged.
module hpdmc_rdcapture #(
  parameter int DW         = 32,
  parameter int BURST      = 4,
  parameter int MAX_LAT    = 15,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [3:0]        cfg_lat,
  input  logic              read_start,
  input  logic [DW-1:0]     dq_rise,
  input  logic [DW-1:0]     dq_fall,
  output logic [2*DW-1:0]   out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              err_overlap,
  output logic              err_overflow,
  input  logic              err_clr
);

  localparam int CW   = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int NW   = $clog2(FIFO_DEPTH + 1);
  localparam int EW   = 2 * DW + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(BURST - 1);
  localparam logic [NW-1:0] CNT_FULL = NW'(FIFO_DEPTH);

  // Delay line: bit i set means a window opens i cycles after the current one.
  logic [MAX_LAT-1:0] r_dly;
  logic [MAX_LAT-1:0] w_dly_next;
  int                 w_lat;

  // Beat counter state: r_active means the current cycle continues a burst at beat count r_cnt.
  logic               r_active;
  logic [CW-1:0]      r_cnt;

  logic               w_open;
  logic               w_beat;
  logic [CW-1:0]      w_cnt;
  logic               w_beat_last;
  logic               w_overlap;

  // FIFO storage: entry = {last, fall, rise}.
  logic [EW-1:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [NW-1:0]      r_count;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [PW-1:0]      w_head_idx;
  logic [EW-1:0]      w_head;

  logic               r_err_overlap;
  logic               r_err_overflow;

  // Effective latency: 0 behaves as 1, anything above the delay-line length clamps to it.
  always_comb begin
    w_lat = int'(cfg_lat);
    if (w_lat == 0) w_lat = 1;
    if (w_lat > MAX_LAT) w_lat = MAX_LAT;
  end

  // Shift pending opens toward slot 0 and schedule the new request at its own latency.
  always_comb begin
    w_dly_next = {1'b0, r_dly[MAX_LAT-1:1]};
    for (int i = 0; i < MAX_LAT; i++) begin
      if (read_start && (i == w_lat - 1)) w_dly_next[i] = 1'b1;
    end
  end

  assign w_open      = r_dly[0];
  assign w_beat      = w_open | r_active;
  assign w_cnt       = w_open ? CNT_INIT : r_cnt;
  assign w_beat_last = (w_cnt == '0);
  // Any open that lands on a cycle still owned by the previous burst cuts that burst short.
  assign w_overlap   = w_open & r_active;

  // Delay line register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_dly <= '0;
    else         r_dly <= w_dly_next;
  end

  // Beat counter: restart at BURST-1 on open, count down, go idle after beat 0.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
    end else if (w_beat) begin
      if (w_beat_last) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_active <= 1'b1;
        r_cnt    <= w_cnt - CW'(1);
      end
    end
  end

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  assign w_pop   = ~w_empty & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the beat.
  assign w_push  = w_beat & (~w_full | w_pop);
  assign w_drop  = w_beat & w_full & ~w_pop;

  // FIFO storage writes.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= {w_beat_last, dq_fall, dq_rise};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + NW'(1);
        2'b01:   r_count <= r_count - NW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // When empty, show the slot just popped so out_data holds its last value.
  assign w_head_idx = w_empty ? (r_rd_ptr - PW'(1)) : r_rd_ptr;
  assign w_head     = r_mem[w_head_idx];

  // Sticky error flags; a new set wins over a simultaneous clear.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_err_overlap  <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      r_err_overlap  <= w_overlap | (r_err_overlap  & ~err_clr);
      r_err_overflow <= w_drop    | (r_err_overflow & ~err_clr);
    end
  end

  assign out_data     = w_head[2*DW-1:0];
  assign out_last     = w_head[2*DW];
  assign out_valid    = ~w_empty;
  assign busy         = (|r_dly) | r_active;
  assign err_overlap  = r_err_overlap;
  assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_hpdmc_rdcapture.sv
// Bench for hpdmc_rdcapture: directed reads, scoreboard queue filled by stimulus,
// popped and compared by a monitor on every accepted output word.
module tb_hpdmc_rdcapture;

  localparam int DW = 32;

  logic            sys_clk = 1'b0;
  logic            sys_rst = 1'b1;
  logic [3:0]      cfg_lat = 4'd3;
  logic            read_start = 1'b0;
  logic [DW-1:0]   dq_rise = '0;
  logic [DW-1:0]   dq_fall = '0;
  logic [2*DW-1:0] out_data;
  logic            out_last;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            busy;
  logic            err_overlap;
  logic            err_overflow;
  logic            err_clr = 1'b0;

  hpdmc_rdcapture #(.DW(DW), .BURST(4), .MAX_LAT(15), .FIFO_DEPTH(8)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .cfg_lat      (cfg_lat),
    .read_start   (read_start),
    .dq_rise      (dq_rise),
    .dq_fall      (dq_fall),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .err_overlap  (err_overlap),
    .err_overflow (err_overflow),
    .err_clr      (err_clr)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [2*DW-1:0] d;
    logic            l;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rel     = 0;

  task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, got, exp, rel);
    end
  endtask

  // Word captured in cycle c is {~c, c}.
  function automatic logic [2*DW-1:0] word_of(input int c);
    logic [DW-1:0] v;
    v = DW'(c);
    return {~v, v};
  endfunction

  // Queue n words from cycles first..first+n-1; optionally tag the final one as last.
  task automatic push_words(input int first, input int n, input bit last_on_final);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.d = word_of(first + i);
      e.l = last_on_final && (i == n - 1);
      q.push_back(e);
    end
  endtask

  // Advance one cycle; inputs change 2 time units after the edge.
  task automatic step();
    @(posedge sys_clk);
    #2;
    rel++;
    read_start = 1'b0;
    err_clr    = 1'b0;
    dq_rise    = DW'(rel);
    dq_fall    = ~DW'(rel);
  endtask

  task automatic go_to(input int n);
    while (rel < n) step();
  endtask

  task automatic do_reset(input logic [3:0] lat, input logic rdy);
    sys_rst = 1'b1;
    step();
    step();
    q.delete();
    sys_rst   = 1'b0;
    cfg_lat   = lat;
    out_ready = rdy;
    rel       = 0;
    dq_rise   = '0;
    dq_fall   = '1;
  endtask

  // Monitor: every accepted word must match the head of the scoreboard.
  always @(negedge sys_clk) begin
    exp_t e;
    if (!sys_rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_word: got %h last %b, required no word (cycle %0d)", out_data, out_last, rel);
      end else begin
        e = q.pop_front();
        check("word", {out_last, out_data}, {e.l, e.d});
      end
    end
  end

  initial begin
    // Test 1: single read, latency 3, plus reset state.
    do_reset(4'd3, 1'b1);
    check("rst_valid", 65'(out_valid), 65'(0));
    check("rst_busy", 65'(busy), 65'(0));
    check("rst_data", {out_last, out_data}, 65'(0));
    check("rst_errs", 65'({err_overlap, err_overflow}), 65'(0));
    go_to(10);
    check("t1_busy10", 65'(busy), 65'(0));
    read_start = 1'b1;
    push_words(13, 4, 1'b1);
    go_to(11);
    check("t1_busy11", 65'(busy), 65'(1));
    go_to(13);
    check("t1_valid13", 65'(out_valid), 65'(0));
    go_to(14);
    check("t1_valid14", 65'(out_valid), 65'(1));
    go_to(16);
    check("t1_busy16", 65'(busy), 65'(1));
    go_to(17);
    check("t1_busy17", 65'(busy), 65'(0));
    go_to(18);
    check("t1_valid18", 65'(out_valid), 65'(0));
    check("t1_drained", 65'(q.size()), 65'(0));

    // Test 2: back-to-back reads at 10 and 14 are seamless.
    do_reset(4'd3, 1'b1);
    go_to(10);
    read_start = 1'b1;
    push_words(13, 4, 1'b1);
    go_to(14);
    read_start = 1'b1;
    push_words(17, 4, 1'b1);
    go_to(20);
    check("t2_busy20", 65'(busy), 65'(1));
    go_to(21);
    check("t2_busy21", 65'(busy), 65'(0));
    go_to(24);
    check("t2_overlap", 65'(err_overlap), 65'(0));
    check("t2_drained", 65'(q.size()), 65'(0));

    // Test 3: overlapping reads at 10 and 12 abandon the first burst.
    do_reset(4'd3, 1'b1);
    go_to(10);
    read_start = 1'b1;
    push_words(13, 2, 1'b0);
    go_to(12);
    read_start = 1'b1;
    push_words(15, 4, 1'b1);
    go_to(14);
    check("t3_overlap14", 65'(err_overlap), 65'(0));
    go_to(16);
    check("t3_overlap16", 65'(err_overlap), 65'(1));
    go_to(20);
    err_clr = 1'b1;
    go_to(21);
    check("t3_overlap_clr", 65'(err_overlap), 65'(0));
    check("t3_drained", 65'(q.size()), 65'(0));

    // Test 4: consumer stalled, three bursts; third burst dropped.
    do_reset(4'd3, 1'b0);
    go_to(10);
    read_start = 1'b1;
    push_words(13, 4, 1'b1);
    go_to(14);
    read_start = 1'b1;
    push_words(17, 4, 1'b1);
    go_to(18);
    read_start = 1'b1;
    go_to(21);
    check("t4_ovf21", 65'(err_overflow), 65'(0));
    go_to(22);
    check("t4_ovf22", 65'(err_overflow), 65'(1));
    go_to(26);
    check("t4_valid_full", 65'(out_valid), 65'(1));
    err_clr = 1'b1;
    go_to(27);
    check("t4_ovf_clr", 65'(err_overflow), 65'(0));
    go_to(28);
    out_ready = 1'b1;
    go_to(37);
    check("t4_valid_empty", 65'(out_valid), 65'(0));
    check("t4_hold_data", 65'(out_data), 65'(word_of(20)));
    check("t4_drained", 65'(q.size()), 65'(0));

    // Test 5: FIFO full but popped in the same cycle as the next beat.
    do_reset(4'd3, 1'b0);
    go_to(10);
    read_start = 1'b1;
    push_words(13, 4, 1'b1);
    go_to(14);
    read_start = 1'b1;
    push_words(17, 4, 1'b1);
    go_to(18);
    read_start = 1'b1;
    push_words(21, 4, 1'b1);
    go_to(21);
    out_ready = 1'b1;
    go_to(22);
    check("t5_ovf22", 65'(err_overflow), 65'(0));
    go_to(36);
    check("t5_ovf36", 65'(err_overflow), 65'(0));
    check("t5_drained", 65'(q.size()), 65'(0));

    // Test 6: cfg_lat=0 acts as latency 1; reset mid-burst discards everything.
    do_reset(4'd0, 1'b1);
    go_to(10);
    read_start = 1'b1;
    push_words(11, 1, 1'b0);
    go_to(11);
    check("t6_valid11", 65'(out_valid), 65'(0));
    go_to(12);
    check("t6_valid12", 65'(out_valid), 65'(1));
    go_to(13);
    sys_rst = 1'b1;
    go_to(14);
    sys_rst = 1'b0;
    check("t6_valid_rst", 65'(out_valid), 65'(0));
    check("t6_busy_rst", 65'(busy), 65'(0));
    go_to(30);
    check("t6_valid30", 65'(out_valid), 65'(0));
    check("t6_drained", 65'(q.size()), 65'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
